mem_access_fsm: RTL

Sequencing controller for the board's memory-access path: it accepts read/write requests from the debounced user keys, serialises address and write data onto an 8-bit byte bus toward the external memory, waits for the memory's acknowledge, and captures 16-bit read data. It produces the 13-bit one-hot controller state consumed by the seven-segment status display, plus read data for that display in the read-done state.

---
 rtl/mem_access_fsm.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_fsm.sv
// -----------------------------------------------------------------------------
// mem_access_fsm
//
// Sequencing controller for the memory-access path. Read and write requests
// from the debounced user keys are serialised onto an 8-bit byte bus toward
// the external memory. The controller then waits for the memory acknowledge
// and, for reads, captures the 16-bit read data. The one-hot controller state
// is exported for the seven-segment status display.
//
// Parameters
//   INIT_CYCLES     cycles spent in RESET after reset release (>= 1)
//   TIMEOUT_CYCLES  max cycles in a WAIT state without ack before abort (>= 2)
//
// Ports
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   rd_req     in   1   read request (level), sampled in IDLE / READ_DONE
//   wr_req     in   1   write request (level), sampled in IDLE / READ_DONE
//   addr       in  16   access address, latched in READ_ST0 / WRITE_ST0
//   wdata      in  16   write data, latched in WRITE_ST0
//   mem_ack    in   1   memory acknowledge, honoured in READ_WAIT / WRITE_WAIT
//   mem_rdata  in  16   read data, captured when mem_ack is seen in READ_WAIT
//   mem_byte   out  8   byte-bus payload, zero unless mem_strobe is high
//   mem_strobe out  1   byte-valid strobe, one cycle per byte
//   mem_cmd    out  1   1 = write, 0 = read; valid from *_ST1 through *_WAIT
//   state      out 13   one-hot controller state
//   rdata      out 16   last captured read data
//   busy       out  1   high except in IDLE and READ_DONE
//   done       out  1   one-cycle completion pulse
//   err        out  1   sticky timeout flag, cleared on entry to *_ST0
// -----------------------------------------------------------------------------
module mem_access_fsm #(
    parameter int INIT_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [7:0]  mem_byte,
    output logic        mem_strobe,
    output logic        mem_cmd,
    output logic [12:0] state,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // One shared counter serves the init delay and the WAIT timeout; the two
    // never run at the same time.
    localparam int CNT_MAX = (INIT_CYCLES > TIMEOUT_CYCLES) ? INIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

    // State encoding is the display encoding: bit index = state number.
    typedef enum logic [12:0] {
        S_RESET      = 13'h0001,
        S_IDLE       = 13'h0002,
        S_READ_ST0   = 13'h0004,
        S_READ_ST1   = 13'h0008,
        S_READ_ST2   = 13'h0010,
        S_READ_WAIT  = 13'h0020,
        S_READ_DONE  = 13'h0040,
        S_WRITE_ST0  = 13'h0080,
        S_WRITE_ST1  = 13'h0100,
        S_WRITE_ST2  = 13'h0200,
        S_WRITE_ST3  = 13'h0400,
        S_WRITE_ST4  = 13'h0800,
        S_WRITE_WAIT = 13'h1000
    } state_t;

    state_t        state_q,      state_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [15:0]   addr_q,       addr_d;
    logic [15:0]   wdata_q,      wdata_d;
    logic [15:0]   rdata_q,      rdata_d;
    logic [7:0]    mem_byte_q,   mem_byte_d;
    logic          mem_strobe_q, mem_strobe_d;
    logic          mem_cmd_q,    mem_cmd_d;
    logic          done_q,       done_d;
    logic          err_q,        err_d;

    logic          in_wait_s;
    logic          timeout_s;

    // Timeout fires on the last permitted WAIT cycle; ack on that cycle wins.
    always_comb begin
        in_wait_s = (state_q == S_READ_WAIT) || (state_q == S_WRITE_WAIT);
        timeout_s = in_wait_s && !mem_ack && (cnt_q == WAIT_LAST);
    end

    // Next-state and shared counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RESET: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_IDLE, S_READ_DONE: begin
                // Read has priority when both keys are down.
                if (rd_req) begin
                    state_d = S_READ_ST0;
                end else if (wr_req) begin
                    state_d = S_WRITE_ST0;
                end else begin
                    state_d = state_q;
                end
            end
            S_READ_ST0:  state_d = S_READ_ST1;
            S_READ_ST1:  state_d = S_READ_ST2;
            S_READ_ST2: begin
                state_d = S_READ_WAIT;
                cnt_d   = CNT_ZERO;
            end
            S_READ_WAIT: begin
                if (mem_ack) begin
                    state_d = S_READ_DONE;
                end else if (timeout_s) begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WRITE_ST0: state_d = S_WRITE_ST1;
            S_WRITE_ST1: state_d = S_WRITE_ST2;
            S_WRITE_ST2: state_d = S_WRITE_ST3;
            S_WRITE_ST3: state_d = S_WRITE_ST4;
            S_WRITE_ST4: begin
                state_d = S_WRITE_WAIT;
                cnt_d   = CNT_ZERO;
            end
            S_WRITE_WAIT: begin
                if (mem_ack) begin
                    state_d = S_IDLE;
                end else if (timeout_s) begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                // A corrupted (non one-hot) state re-runs the init sequence.
                state_d = S_RESET;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Latches, completion/error flags and read-data capture.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        if ((state_q == S_READ_ST0) || (state_q == S_WRITE_ST0)) begin
            addr_d = addr;
        end else begin
            addr_d = addr_q;
        end

        if (state_q == S_WRITE_ST0) begin
            wdata_d = wdata;
        end else begin
            wdata_d = wdata_q;
        end

        if ((state_q == S_READ_WAIT) && mem_ack) begin
            rdata_d = mem_rdata;
        end else begin
            rdata_d = rdata_q;
        end

        // Registered pulse lands in the first READ_DONE / IDLE cycle.
        done_d = in_wait_s && mem_ack;

        // Cleared on entry so err already reads 0 while in *_ST0.
        if ((state_d == S_READ_ST0) || (state_d == S_WRITE_ST0)) begin
            err_d = 1'b0;
        end else if (timeout_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Byte-bus outputs are decoded from the next state so that the registered
    // copy lines up with the state it belongs to. The *_d latch values are used
    // because the address is captured on the same edge that enters *_ST1.
    always_comb begin
        mem_byte_d   = 8'h00;
        mem_strobe_d = 1'b0;
        case (state_d)
            S_READ_ST1, S_WRITE_ST1: begin
                mem_byte_d   = addr_d[7:0];
                mem_strobe_d = 1'b1;
            end
            S_READ_ST2, S_WRITE_ST2: begin
                mem_byte_d   = addr_d[15:8];
                mem_strobe_d = 1'b1;
            end
            S_WRITE_ST3: begin
                mem_byte_d   = wdata_d[7:0];
                mem_strobe_d = 1'b1;
            end
            S_WRITE_ST4: begin
                mem_byte_d   = wdata_d[15:8];
                mem_strobe_d = 1'b1;
            end
            default: begin
                mem_byte_d   = 8'h00;
                mem_strobe_d = 1'b0;
            end
        endcase
    end

    // Command direction is held for the whole transfer and wait phase.
    always_comb begin
        mem_cmd_d = 1'b0;
        case (state_d)
            S_WRITE_ST1, S_WRITE_ST2, S_WRITE_ST3,
            S_WRITE_ST4, S_WRITE_WAIT: mem_cmd_d = 1'b1;
            default:                   mem_cmd_d = 1'b0;
        endcase
    end

    // All controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_RESET;
            cnt_q        <= CNT_ZERO;
            addr_q       <= 16'h0000;
            wdata_q      <= 16'h0000;
            rdata_q      <= 16'h0000;
            mem_byte_q   <= 8'h00;
            mem_strobe_q <= 1'b0;
            mem_cmd_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            mem_byte_q   <= mem_byte_d;
            mem_strobe_q <= mem_strobe_d;
            mem_cmd_q    <= mem_cmd_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign state      = state_q;
    assign busy       = !((state_q == S_IDLE) || (state_q == S_READ_DONE));
    assign mem_byte   = mem_byte_q;
    assign mem_strobe = mem_strobe_q;
    assign mem_cmd    = mem_cmd_q;
    assign rdata      = rdata_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
